// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the matrix keypad scanner.
//   scan_state_t  - scanner FSM states
//   MAX_COLS      - widest column bus the helpers accept
//   ALL_HIGH      - idle (no key) column pattern at MAX_COLS width
//   onehot0_low() - {valid, index} of the single low column; valid=0 when
//                   zero or several columns are low
//   keymap_4x4()  - legacy 4x4 lock legend for a linear key code
package keypad_pkg;

  typedef enum logic [2:0] {SCAN, PRESS_DB, EVAL, HOLD, REL_DB} scan_state_t;

  localparam int MAX_COLS = 32;
  localparam int CIW      = $clog2(MAX_COLS);
  localparam logic [MAX_COLS-1:0] ALL_HIGH = '1;

  typedef struct packed {
    logic           valid;
    logic [CIW-1:0] idx;
  } col_pick_t;

  // Callers pad unused upper columns high so they never count as pressed.
  function automatic col_pick_t onehot0_low(input logic [MAX_COLS-1:0] col);
    col_pick_t r;
    int        n;
    r = '0;
    n = 0;
    for (int i = 0; i < MAX_COLS; i++) begin
      if (!col[i]) begin
        n++;
        r.idx = CIW'(i);
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction

  // Rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / F 0 E D
  function automatic logic [3:0] keymap_4x4(input logic [3:0] code);
    case (code)
      4'd0:    return 4'h1;
      4'd1:    return 4'h2;
      4'd2:    return 4'h3;
      4'd3:    return 4'hA;
      4'd4:    return 4'h4;
      4'd5:    return 4'h5;
      4'd6:    return 4'h6;
      4'd7:    return 4'hB;
      4'd8:    return 4'h7;
      4'd9:    return 4'h8;
      4'd10:   return 4'h9;
      4'd11:   return 4'hC;
      4'd12:   return 4'hF;
      4'd13:   return 4'h0;
      4'd14:   return 4'hE;
      default: return 4'hD;
    endcase
  endfunction

endpackage

// File: rtl/kp_stable_counter.sv
// kp_stable_counter: counts consecutive qualifying cycles, saturating at TARGET.
//   clk, reset - clock, synchronous active-high reset
//   clr        - zero the count
//   match      - this cycle qualifies; count advances
//   done       - count has reached TARGET
module kp_stable_counter #(
  parameter int WIDTH  = 4,
  parameter int TARGET = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic match,
  output logic done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (match && (cnt != WIDTH'(TARGET)))
      cnt <= cnt + 1'b1;
  end

  assign done = (cnt == WIDTH'(TARGET));

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: row-scanning matrix keypad front end.
// Drives one row low at a time, debounces press and release, rejects chords
// and hands out a linear key code (row*COLS + col) over valid/ready.
//   clk, reset   - clock, synchronous active-high reset
//   col_matrix   - column inputs, active low, already synchronised
//   lin_matrix   - row drive, one-cold
//   key_code     - linear key code, stable while key_valid
//   key_valid    - key available
//   key_ready    - consumer accepts (transfer on valid && ready)
//   key_overrun  - pulse: new key dropped, previous still pending
//   multi_key    - pulse: chord rejected
// Optional build macro KEYPAD_REPEAT_EN enables auto-repeat of a held key.
//
// state    | meaning
// SCAN     | dwell on current row, then sample columns
// PRESS_DB | row frozen, debounce the latched column pattern
// EVAL     | one cycle: emit key, overrun or chord pulse
// HOLD     | wait for all columns high (auto-repeat runs here)
// REL_DB   | debounce release, then advance row
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DWELL    = 2,
  parameter int DEBOUNCE_CYC  = 100,
  parameter int REPEAT_DELAY  = 5000,
  parameter int REPEAT_PERIOD = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [COLS-1:0]              col_matrix,
  output logic [ROWS-1:0]              lin_matrix,
  output logic [$clog2(ROWS*COLS)-1:0] key_code,
  output logic                         key_valid,
  input  logic                         key_ready,
  output logic                         key_overrun,
  output logic                         multi_key
);

  localparam int KW   = $clog2(ROWS*COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int DW   = $clog2(SCAN_DWELL+1);
  localparam int CNTW = $clog2(DEBOUNCE_CYC+1);
  localparam logic [COLS-1:0] COL_IDLE   = '1;
  localparam logic [DW-1:0]   DWELL_LOAD = DW'(SCAN_DWELL-1);

  scan_state_t           state;
  logic [RW-1:0]         row;
  logic [RW-1:0]         next_row;
  logic [DW-1:0]         dwell;
  logic [COLS-1:0]       pattern;
  logic [MAX_COLS-1:0]   pat_ext;
  col_pick_t             sel;
  logic [KW-1:0]         new_code;
  logic                  db_match;
  logic                  db_done;
  logic                  rep_fire;
  logic                  emit;

  function automatic logic [ROWS-1:0] row_drive(input logic [RW-1:0] r);
    return ~(ROWS'(1) << r);
  endfunction

  assign next_row = (row == RW'(ROWS-1)) ? '0 : row + 1'b1;

  always_comb begin
    pat_ext            = ALL_HIGH;
    pat_ext[COLS-1:0]  = pattern;
  end

  assign sel      = onehot0_low(pat_ext);
  assign new_code = KW'(row) * KW'(COLS) + KW'(sel.idx);

  // One counter serves both debounce states; it is zero everywhere else.
  assign db_match = ((state == PRESS_DB) && (col_matrix == pattern)) ||
                    ((state == REL_DB)   && (col_matrix == COL_IDLE));

  kp_stable_counter #(
    .WIDTH  (CNTW),
    .TARGET (DEBOUNCE_CYC)
  ) u_stable_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (!db_match),
    .match (db_match),
    .done  (db_done)
  );

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPW     = $clog2(REP_MAX+1);
  localparam logic [RPW-1:0] DELAY_LOAD  = RPW'(REPEAT_DELAY-1);
  localparam logic [RPW-1:0] PERIOD_LOAD = RPW'(REPEAT_PERIOD-1);

  logic [RPW-1:0] rep_cnt;
  logic           same_key;

  // Only a single key that still matches the latched pattern keeps the timer running.
  assign same_key = sel.valid && (col_matrix == pattern);
  assign rep_fire = (state == HOLD) && same_key && (rep_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset || (state != HOLD) || !same_key)
      rep_cnt <= DELAY_LOAD;
    else if (rep_cnt == '0)
      rep_cnt <= PERIOD_LOAD;
    else
      rep_cnt <= rep_cnt - 1'b1;
  end
`else
  logic unused_repeat;
  assign unused_repeat = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
  assign rep_fire      = 1'b0;
`endif

  assign emit = (state == EVAL) || rep_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      row         <= '0;
      lin_matrix  <= row_drive('0);
      dwell       <= DWELL_LOAD;
      pattern     <= COL_IDLE;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      key_overrun <= 1'b0;
      multi_key   <= 1'b0;

      if (key_valid && key_ready)
        key_valid <= 1'b0;

      // Loading wins over a same-cycle acceptance, so valid stays high.
      if (emit) begin
        if (sel.valid) begin
          if (!key_valid || key_ready) begin
            key_code  <= new_code;
            key_valid <= 1'b1;
          end else begin
            key_overrun <= 1'b1;
          end
        end else begin
          multi_key <= 1'b1;
        end
      end

      case (state)
        SCAN: begin
          if (dwell != '0) begin
            dwell <= dwell - 1'b1;
          end else begin
            dwell <= DWELL_LOAD;
            if (col_matrix == COL_IDLE) begin
              row        <= next_row;
              lin_matrix <= row_drive(next_row);
            end else begin
              pattern <= col_matrix;
              state   <= PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (col_matrix != pattern)
            state <= SCAN;
          else if (db_done)
            state <= EVAL;
        end
        EVAL: state <= HOLD;
        HOLD: begin
          if (col_matrix == COL_IDLE)
            state <= REL_DB;
        end
        REL_DB: begin
          if (col_matrix != COL_IDLE) begin
            state <= HOLD;
          end else if (db_done) begin
            state      <= SCAN;
            row        <= next_row;
            lin_matrix <= row_drive(next_row);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
module tb_keypad_matrix_scanner;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_matrix;
  logic [3:0] lin_matrix;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_overrun;
  logic       multi_key;

  logic [15:0] pressed;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] legend;
  } exp_t;

  exp_t exp_q[$];
  int   xfer_t[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_ovr  = 0;
  int   n_multi = 0;
  logic hold_chk = 1'b0;
  logic [3:0] held_code = '0;

  keypad_matrix_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DWELL(2), .DEBOUNCE_CYC(8),
    .REPEAT_DELAY(50), .REPEAT_PERIOD(20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .col_matrix  (col_matrix),
    .lin_matrix  (lin_matrix),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_overrun (key_overrun),
    .multi_key   (multi_key)
  );

  always #5 clk = ~clk;

  // Key switch matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_matrix = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !lin_matrix[r])
          col_matrix[c] = 1'b0;
  end

  // Monitor: pops expected keys on every transfer and watches stall stability.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      hold_chk = 1'b0;
    end else begin
      if (key_overrun) n_ovr++;
      if (multi_key)   n_multi++;
      if (hold_chk) begin
        checks++;
        if (!key_valid || key_code != held_code) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b code=%0d required valid=1 code=%0d",
                   key_valid, key_code, held_code);
        end
      end
      if (key_valid && key_ready) begin
        xfer_t.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_key: code=%0d at cycle %0d required no transfer", key_code, cyc);
        end else begin
          e = exp_q.pop_front();
          if (key_code != e.code || keymap_4x4(key_code) != e.legend) begin
            errors++;
            $display("FAIL key_xfer: code=%0d legend=%h required code=%0d legend=%h",
                     key_code, keymap_4x4(key_code), e.code, e.legend);
          end
        end
      end
      hold_chk  = key_valid && !key_ready;
      held_code = key_code;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push_key(input logic [3:0] code, input logic [3:0] legend);
    exp_t e;
    e.code   = code;
    e.legend = legend;
    exp_q.push_back(e);
  endtask

  initial begin
    int   ovr0, multi0, t0;
    logic ok;
    logic [3:0] seen;

    reset     = 1'b1;
    key_ready = 1'b1;
    pressed   = '0;
    tick(3);
    check("rst_lin",     lin_matrix, 4'b1110);
    check("rst_code",    key_code, 0);
    check("rst_valid",   key_valid, 0);
    check("rst_overrun", key_overrun, 0);
    check("rst_multi",   multi_key, 0);
    reset = 1'b0;
    tick(2);

    // 1: clean press of row2/col1 -> code 9, legend 8
    ovr0 = n_ovr; multi0 = n_multi;
    push_key(4'd9, 4'h8);
    pressed[9] = 1'b1;
    tick(40);
    pressed[9] = 1'b0;
    tick(40);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_overrun", n_ovr - ovr0, 0);
    check("t1_multi", n_multi - multi0, 0);

    // 2: bouncing key 6, then steady -> one key only
    ovr0 = n_ovr; multi0 = n_multi;
    repeat (4) begin
      pressed[6] = 1'b1;
      tick(3);
      pressed[6] = 1'b0;
      tick(2);
    end
    push_key(4'd6, 4'h6);
    pressed[6] = 1'b1;
    tick(40);
    pressed[6] = 1'b0;
    tick(40);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_overrun", n_ovr - ovr0, 0);
    check("t2_multi", n_multi - multi0, 0);

    // 5: reset during press debounce aborts the key
    check("t5_pre_code", key_code, 6);
    pressed[9] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick(1);
      if (lin_matrix == 4'b1011) ok = 1'b1;
    end
    check("t5_reach_row2", ok, 1);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t5_lin",     lin_matrix, 4'b1110);
    check("t5_code",    key_code, 0);
    check("t5_valid",   key_valid, 0);
    check("t5_overrun", key_overrun, 0);
    check("t5_multi",   multi_key, 0);
    pressed[9] = 1'b0;
    tick(40);
    check("t5_queue_empty", exp_q.size(), 0);

    // 3: consumer stalled; second key overruns, first stays
    ovr0 = n_ovr;
    key_ready = 1'b0;
    push_key(4'd0, 4'h1);
    pressed[0] = 1'b1;
    tick(40);
    pressed[0] = 1'b0;
    tick(40);
    pressed[15] = 1'b1;
    tick(40);
    pressed[15] = 1'b0;
    tick(40);
    check("t3_valid_pending", key_valid, 1);
    check("t3_code_held", key_code, 0);
    check("t3_overrun", n_ovr - ovr0, 1);
    key_ready = 1'b1;
    tick(5);
    check("t3_queue_empty", exp_q.size(), 0);
    check("t3_valid_cleared", key_valid, 0);

    // 4: chord on row1 (col0 + col3)
    multi0 = n_multi;
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    tick(40);
    check("t4_valid", key_valid, 0);
    pressed[4] = 1'b0;
    pressed[7] = 1'b0;
    tick(40);
    check("t4_multi", n_multi - multi0, 1);
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | ~lin_matrix;
    end
    check("t4_scan_resumed", seen, 4'hF);

    // 6: long hold of key 5
    xfer_t.delete();
    push_key(4'd5, 4'h5);
`ifdef KEYPAD_REPEAT_EN
    repeat (4) push_key(4'd5, 4'h5);
`endif
    pressed[5] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick(1);
      if (xfer_t.size() > 0) ok = 1'b1;
    end
    check("t6_first_key", ok, 1);
    tick(115);
    pressed[5] = 1'b0;
    tick(40);
`ifdef KEYPAD_REPEAT_EN
    check("t6_key_count", xfer_t.size(), 5);
    if (xfer_t.size() == 5) begin
      t0 = xfer_t[0];
      for (int i = 1; i < 5; i++)
        check($sformatf("t6_repeat%0d_offset", i), xfer_t[i] - t0, 30 + 20*i);
    end
`else
    check("t6_key_count", xfer_t.size(), 1);
`endif
    check("t6_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
